// File: rtl/alm_pkg.sv
// Shared types and default sizing for the ALM accumulation slice.
//   state_t   : accumulator FSM states
//   DEF_*     : default operand / accumulator / counter widths
package alm_pkg;

  localparam int unsigned DEF_N     = 16;
  localparam int unsigned DEF_ACC_W = 40;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_add.sv
// Unsigned saturating adder.
//   a, b : W-bit unsigned operands
//   sum  : a+b, clamped to all-ones on carry-out
//   ovf  : carry-out of the unclamped addition
module sat_add #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign ovf  = full[W];
  assign sum  = full[W] ? '1 : full[W-1:0];

endmodule

// File: rtl/alm_dot_accum.sv
// Saturating dot-product accumulator behind the ALM approximate multiplier.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : product beat handshake (in_ready low only in HOLD)
//   in_prod, in_last    : 2N-bit unsigned product, end-of-vector flag
//   clr                 : abort a partial accumulation (ignored in HOLD)
//   out_valid/out_ready : result handshake (out_valid high in HOLD)
//   out_acc/cnt/ovf     : registered sum, beat count, sticky saturation flag
module alm_dot_accum
  import alm_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned ACC_W = DEF_ACC_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_prod,
  input  logic             in_last,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  state_t           state, state_n;
  logic [ACC_W-1:0] acc, acc_n, acc_base, acc_sum;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_base, cnt_sum;
  logic             ovf, ovf_n, acc_carry, cnt_carry, beat_ovf;
  logic [ACC_W-1:0] out_acc_n;
  logic [CNT_W-1:0] out_cnt_n;
  logic             out_ovf_n;
  logic             beat, take, fresh;

  // Handshake flags depend on state only.
  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign beat      = in_valid && in_ready;
  assign take      = out_valid && out_ready;

  // A beat in IDLE starts a new vector: sum, count and flag restart from zero.
  assign fresh    = (state == IDLE);
  assign acc_base = fresh ? '0 : acc;
  assign cnt_base = fresh ? '0 : cnt;
  assign beat_ovf = (!fresh && ovf) || acc_carry || cnt_carry;

  sat_add #(.W(ACC_W)) u_acc_add (
    .a   (acc_base),
    .b   (ACC_W'(in_prod)),
    .sum (acc_sum),
    .ovf (acc_carry)
  );

  sat_add #(.W(CNT_W)) u_cnt_add (
    .a   (cnt_base),
    .b   (CNT_W'(1)),
    .sum (cnt_sum),
    .ovf (cnt_carry)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_acc <= '0;
      out_cnt <= '0;
      out_ovf <= 1'b0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      cnt     <= cnt_n;
      ovf     <= ovf_n;
      out_acc <= out_acc_n;
      out_cnt <= out_cnt_n;
      out_ovf <= out_ovf_n;
    end
  end

  // Next-state and next-value logic.
  always_comb begin
    state_n   = state;
    acc_n     = acc;
    cnt_n     = cnt;
    ovf_n     = ovf;
    out_acc_n = out_acc;
    out_cnt_n = out_cnt;
    out_ovf_n = out_ovf;
    case (state)
      IDLE, ACCUM: begin
        // clr beats a coincident beat: the beat is dropped.
        if (clr) begin
          state_n = IDLE;
          acc_n   = '0;
          cnt_n   = '0;
          ovf_n   = 1'b0;
        end else if (beat) begin
          acc_n = acc_sum;
          cnt_n = cnt_sum;
          ovf_n = beat_ovf;
          if (in_last) begin
            state_n   = HOLD;
            out_acc_n = acc_sum;
            out_cnt_n = cnt_sum;
            out_ovf_n = beat_ovf;
          end else begin
            state_n = ACCUM;
          end
        end
      end
      HOLD: begin
        if (take) begin
          state_n = IDLE;
          acc_n   = '0;
          cnt_n   = '0;
          ovf_n   = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        acc_n   = '0;
        cnt_n   = '0;
        ovf_n   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_alm_dot_accum.sv
// Self-checking bench: a default-sized instance (ACC_W=40, CNT_W=8) and a
// narrow instance (ACC_W=32, CNT_W=2) share one stimulus stream and are each
// checked against a whole-vector arithmetic reference.
module tb_alm_dot_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_prod;
  logic        in_last;
  logic        clr;
  logic        out_ready;

  logic        ready0, ov0, ovf0;
  logic [39:0] acc0;
  logic [7:0]  cnt0;
  logic        ready1, ov1, ovf1;
  logic [31:0] acc1;
  logic [1:0]  cnt1;

  int n_cmp = 0;
  int n_err = 0;

  longint unsigned q[$];

  always #5 clk = ~clk;

  alm_dot_accum #(.N(16), .ACC_W(40), .CNT_W(8)) d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready0),
    .in_prod(in_prod), .in_last(in_last), .clr(clr), .out_valid(ov0),
    .out_ready(out_ready), .out_acc(acc0), .out_cnt(cnt0), .out_ovf(ovf0)
  );

  alm_dot_accum #(.N(16), .ACC_W(32), .CNT_W(2)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready1),
    .in_prod(in_prod), .in_last(in_last), .clr(clr), .out_valid(ov1),
    .out_ready(out_ready), .out_acc(acc1), .out_cnt(cnt1), .out_ovf(ovf1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-vector reference: saturation of a monotone running sum equals
  // clamping the exact total; the counter clamps the exact beat count.
  function automatic void model(input int unsigned acc_w, input int unsigned cnt_w,
                                output longint unsigned ea, output longint unsigned ec,
                                output logic eo);
    longint unsigned tot, amax, cmax, n;
    tot  = 0;
    amax = (64'd1 << acc_w) - 64'd1;
    cmax = (64'd1 << cnt_w) - 64'd1;
    foreach (q[i]) tot += q[i];
    n  = 64'(q.size());
    ea = (tot > amax) ? amax : tot;
    ec = (n > cmax) ? cmax : n;
    eo = (tot > amax) || (n > cmax);
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_rdy0"}, 64'(ready0), 64'd1);
    chk({tag, "_ov0"},  64'(ov0),    64'd0);
    chk({tag, "_rdy1"}, 64'(ready1), 64'd1);
    chk({tag, "_ov1"},  64'(ov1),    64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk_idle(tag);
    chk({tag, "_acc0"}, 64'(acc0), 64'd0);
    chk({tag, "_cnt0"}, 64'(cnt0), 64'd0);
    chk({tag, "_ovf0"}, 64'(ovf0), 64'd0);
    chk({tag, "_acc1"}, 64'(acc1), 64'd0);
    chk({tag, "_cnt1"}, 64'(cnt1), 64'd0);
    chk({tag, "_ovf1"}, 64'(ovf1), 64'd0);
  endtask

  task automatic chk_res(input string tag, input longint unsigned ea0, input longint unsigned ec0,
                         input logic eo0, input longint unsigned ea1,
                         input longint unsigned ec1, input logic eo1);
    chk({tag, "_acc0"}, 64'(acc0), ea0);
    chk({tag, "_cnt0"}, 64'(cnt0), ec0);
    chk({tag, "_ovf0"}, 64'(ovf0), 64'(eo0));
    chk({tag, "_acc1"}, 64'(acc1), ea1);
    chk({tag, "_cnt1"}, 64'(cnt1), ec1);
    chk({tag, "_ovf1"}, 64'(ovf1), 64'(eo1));
  endtask

  // Drive the vector in q (last flag on the final beat), then check the
  // presented result, hold it for 'hold' cycles and release it.
  task automatic run_vec(input string tag, input int hold, input bit clr_hold, input bit gaps);
    longint unsigned ea0, ec0, ea1, ec1;
    logic eo0, eo1;
    model(40, 8, ea0, ec0, eo0);
    model(32, 2, ea1, ec1, eo1);
    for (int i = 0; i < q.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        tick();
        chk_idle({tag, "_gap"});
      end
      chk({tag, "_beat_rdy0"}, 64'(ready0), 64'd1);
      chk({tag, "_beat_rdy1"}, 64'(ready1), 64'd1);
      in_valid = 1'b1;
      in_prod  = 32'(q[i]);
      in_last  = (i == q.size() - 1);
      tick();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_ov0"},  64'(ov0),    64'd1);
    chk({tag, "_ov1"},  64'(ov1),    64'd1);
    chk({tag, "_rdy0"}, 64'(ready0), 64'd0);
    chk_res(tag, ea0, ec0, eo0, ea1, ec1, eo1);
    for (int h = 0; h < hold; h++) begin
      clr      = clr_hold && (h == 0);
      in_valid = 1'b1;
      tick();
      clr = 1'b0;
      chk({tag, "_hold_ov0"},  64'(ov0),    64'd1);
      chk({tag, "_hold_rdy1"}, 64'(ready1), 64'd0);
      chk_res({tag, "_hold"}, ea0, ec0, eo0, ea1, ec1, eo1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_idle({tag, "_rel"});
    chk_res({tag, "_kept"}, ea0, ec0, eo0, ea1, ec1, eo1);
  endtask

  // Feed q as non-final beats, then a beat with clr that must be dropped.
  task automatic abort_vec(input string tag);
    foreach (q[i]) begin
      in_valid = 1'b1;
      in_prod  = 32'(q[i]);
      in_last  = 1'b0;
      tick();
    end
    clr     = 1'b1;
    in_prod = $urandom;
    in_last = 1'b1;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk_idle(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_last   = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk_zero("reset");

    q = '{5, 7, 9};
    run_vec("basic", 0, 1'b0, 1'b0);

    q = '{64'hFFFF_FFFF};
    run_vec("single_hold", 4, 1'b0, 1'b0);

    q = '{64'hFFFF_FFFF, 64'h2};
    run_vec("acc_sat", 1, 1'b0, 1'b0);
    q = '{1};
    run_vec("after_sat", 0, 1'b0, 1'b0);

    q = '{1, 1, 1, 1, 1};
    run_vec("cnt_sat", 0, 1'b0, 1'b0);

    q = '{10, 20};
    abort_vec("clr_beat");
    q = '{4};
    run_vec("after_clr", 3, 1'b1, 1'b0);

    // Reset while accumulating (acc=50) with a final beat offered.
    q = '{10, 40};
    foreach (q[i]) begin
      in_valid = 1'b1;
      in_prod  = 32'(q[i]);
      tick();
    end
    rst_n   = 1'b0;
    in_prod = 32'd5;
    in_last = 1'b1;
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk_zero("rst_accum");

    // Reset while a result is presented and being accepted.
    in_valid = 1'b1;
    in_prod  = 32'd77;
    in_last  = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("pre_rst_hold_ov0", 64'(ov0), 64'd1);
    rst_n     = 1'b0;
    out_ready = 1'b1;
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b0;
    chk_zero("rst_hold");

    q = '{8};
    run_vec("after_rst", 0, 1'b0, 1'b0);

    for (int v = 0; v < 24; v++) begin
      int len;
      len = $urandom_range(1, 6);
      q.delete();
      for (int b = 0; b < len; b++) begin
        case ($urandom_range(0, 2))
          0:       q.push_back(64'($urandom_range(0, 255)));
          1:       q.push_back(64'($urandom));
          default: q.push_back(64'h0000_0000_FFFF_FFFF - 64'($urandom_range(0, 15)));
        endcase
      end
      if ($urandom_range(0, 4) == 0) begin
        abort_vec("rnd_abort");
      end else begin
        run_vec("rnd", $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
